// File: rtl/piece_fall_ctrl_if.sv
// Handshake and pixel-output bundle between the piece controller and its neighbours.
// The slave modport is the controller; the master modport drives commands and reads coordinates.
interface piece_fall_ctrl_if;
    logic        frame_start;
    logic        spawn;
    logic [2:0]  spawn_type;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic        landed;
    logic [31:0] b1x, b1y, b2x, b2y, b3x, b3y, b4x, b4y;
    logic [31:0] block_color;

    modport slave (
        input  frame_start, spawn, spawn_type, cmd_valid, cmd,
        output cmd_ready, landed, b1x, b1y, b2x, b2y, b3x, b3y, b4x, b4y, block_color
    );

    modport master (
        output frame_start, spawn, spawn_type, cmd_valid, cmd,
        input  cmd_ready, landed, b1x, b1y, b2x, b2y, b3x, b3y, b4x, b4y, block_color
    );
endinterface

// File: rtl/piece_fall_ctrl.sv
// Falling-tetromino controller: anchor + shape table, frame gravity, wall/floor clamp, frame-synced outputs.
// Define HARD_DROP_EN to make cmd 11 drop the piece straight to the floor.
//   state     | meaning
//   ST_IDLE   | no piece, outputs parked, waiting for spawn
//   ST_SPAWN  | place new piece at col 3 / row 0
//   ST_FALL   | accepting moves, gravity running
//   ST_LANDED | piece on floor, outputs frozen, waiting for spawn
module piece_fall_ctrl #(
    parameter int CELL           = 20,
    parameter int FIELD_X0       = 220,
    parameter int FIELD_Y0       = 40,
    parameter int COLS           = 10,
    parameter int ROWS           = 20,
    parameter int GRAVITY_FRAMES = 30,
    parameter int PARK_X         = 700
) (
    input logic              clock,
    input logic              reset,
    piece_fall_ctrl_if.slave bus
);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);
    localparam int GW = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPAWN  = 2'd1,
        ST_FALL   = 2'd2,
        ST_LANDED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    type_q, type_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [GW-1:0] grav_q, grav_d;
    logic          landed_q, landed_d;
    logic          cmd_ready_c;

    logic [9:0]    bx_q [4];
    logic [9:0]    by_q [4];
    logic [23:0]   color_q;

    logic [7:0]    shp_dx;
    logic [3:0]    shp_dy;
    int            shp_w, shp_h;
    logic [23:0]   shp_color;
    logic [9:0]    sh_x [4];
    logic [9:0]    sh_y [4];

    logic          grav_fire, cmd_acc, do_down;

    // Offsets packed block4..block1: dx two bits each, dy one bit each.
    always_comb begin
        shp_dx    = 8'b11_10_01_00;
        shp_dy    = 4'b0000;
        shp_w     = 4;
        shp_h     = 1;
        shp_color = 24'h00FFFF;
        case (type_q)
            3'd1: begin shp_dx = 8'b01_00_01_00; shp_dy = 4'b1100; shp_w = 2; shp_h = 2; shp_color = 24'hFFFF00; end
            3'd2: begin shp_dx = 8'b01_10_01_00; shp_dy = 4'b1000; shp_w = 3; shp_h = 2; shp_color = 24'h800080; end
            3'd3: begin shp_dx = 8'b01_00_10_01; shp_dy = 4'b1100; shp_w = 3; shp_h = 2; shp_color = 24'h00FF00; end
            3'd4: begin shp_dx = 8'b10_01_01_00; shp_dy = 4'b1100; shp_w = 3; shp_h = 2; shp_color = 24'hFF0000; end
            3'd5: begin shp_dx = 8'b10_01_00_00; shp_dy = 4'b1110; shp_w = 3; shp_h = 2; shp_color = 24'h0000FF; end
            3'd6: begin shp_dx = 8'b10_01_00_10; shp_dy = 4'b1110; shp_w = 3; shp_h = 2; shp_color = 24'hFFA500; end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sh_x[i] = 10'(FIELD_X0 + CELL * (int'(col_q) + int'(shp_dx[2*i +: 2])));
            sh_y[i] = 10'(FIELD_Y0 + CELL * (int'(row_q) + int'(shp_dy[i])));
        end
    end

    assign grav_fire = (state_q == ST_FALL) && bus.frame_start && (grav_q == '0);
    assign cmd_acc   = (state_q == ST_FALL) && !grav_fire && bus.cmd_valid;
    assign do_down   = grav_fire || (cmd_acc && (bus.cmd == 2'b10));

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        col_d       = col_q;
        row_d       = row_q;
        grav_d      = grav_q;
        landed_d    = 1'b0;
        cmd_ready_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_LANDED: begin
                // Type is captured alongside the spawn pulse so the source need not hold it.
                if (bus.spawn) begin
                    state_d = ST_SPAWN;
                    type_d  = (bus.spawn_type == 3'd7) ? 3'd0 : bus.spawn_type;
                end
            end
            ST_SPAWN: begin
                col_d   = CW'(3);
                row_d   = '0;
                grav_d  = GW'(GRAVITY_FRAMES - 1);
                state_d = ST_FALL;
            end
            ST_FALL: begin
                cmd_ready_c = !grav_fire;
                if (bus.frame_start) begin
                    grav_d = grav_fire ? GW'(GRAVITY_FRAMES - 1) : grav_q - 1'b1;
                end
                if (do_down) begin
                    if (int'(row_q) + shp_h < ROWS) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        landed_d = 1'b1;
                        state_d  = ST_LANDED;
                    end
                end else if (cmd_acc) begin
                    case (bus.cmd)
                        2'b00: if (col_q != '0) col_d = col_q - 1'b1;
                        2'b01: if (int'(col_q) + shp_w < COLS) col_d = col_q + 1'b1;
                        2'b11: begin
`ifdef HARD_DROP_EN
                            row_d    = RW'(ROWS - shp_h);
                            landed_d = 1'b1;
                            state_d  = ST_LANDED;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            type_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            grav_q   <= GW'(GRAVITY_FRAMES - 1);
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            col_q    <= col_d;
            row_q    <= row_d;
            grav_q   <= grav_d;
            landed_q <= landed_d;
        end
    end

    // Outputs sample the pre-edge shadow, so same-edge updates show up one frame later.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                bx_q[i] <= 10'(PARK_X);
                by_q[i] <= '0;
            end
            color_q <= '0;
        end else if (bus.frame_start && (state_q == ST_FALL || state_q == ST_LANDED)) begin
            for (int i = 0; i < 4; i++) begin
                bx_q[i] <= sh_x[i];
                by_q[i] <= sh_y[i];
            end
            color_q <= shp_color;
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.landed      = landed_q;
    assign bus.b1x         = {22'd0, bx_q[0]};
    assign bus.b1y         = {22'd0, by_q[0]};
    assign bus.b2x         = {22'd0, bx_q[1]};
    assign bus.b2y         = {22'd0, by_q[1]};
    assign bus.b3x         = {22'd0, bx_q[2]};
    assign bus.b3y         = {22'd0, by_q[2]};
    assign bus.b4x         = {22'd0, bx_q[3]};
    assign bus.b4y         = {22'd0, by_q[3]};
    assign bus.block_color = {8'd0, color_q};
endmodule
